// File: rtl/pwm_ctrl_pkg.sv
// Shared types and helpers for the PWM controller family:
// FSM state encoding, default widths and saturating duty arithmetic.
package pwm_ctrl_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } state_e;

    // Operands are zero-extended duty values, so the sum never wraps.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned ceil);
        int unsigned s;
        s = a + b;
        return (s > ceil) ? ceil : s;
    endfunction

    function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b,
                                            input int unsigned floor);
        return (a < floor + b) ? floor : a - b;
    endfunction

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Config/status bundle between the CPU-side config logic (master)
// and the fade sequencer (slave).
interface pwm_fade_ctrl_if
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DWELL_W = DEF_DWELL_W
);
    logic               start;
    logic               stop;
    logic [WIDTH-1:0]   min_duty;
    logic [WIDTH-1:0]   max_duty;
    logic [WIDTH-1:0]   step;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
    logic [WIDTH-1:0]   duty;
    logic               busy;
    logic               done;
    logic               period_tick;

    modport master (
        output start, stop, min_duty, max_duty, step, dwell, loop,
        input  duty, busy, done, period_tick
    );

    modport slave (
        input  start, stop, min_duty, max_duty, step, dwell, loop,
        output duty, busy, done, period_tick
    );

endinterface

// File: rtl/pwm_period_timer.sv
// Free-running mirror of the PWM counter; period_tick marks the last
// clock of each 2**WIDTH-clock period.
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    output logic period_tick
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign period_tick = (cnt == {WIDTH{1'b1}});

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Triangular duty ramp sequencer for a PWM generator; duty and state only
// move on period boundaries so the generator never sees a mid-period change.
module pwm_fade_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic           clk,
    input  logic           rst,
    pwm_fade_ctrl_if.slave bus
);

    state_e             state;
    logic [WIDTH-1:0]   duty_q;
    logic [WIDTH-1:0]   min_l;
    logic [WIDTH-1:0]   max_l;
    logic [WIDTH-1:0]   step_l;
    logic [DWELL_W-1:0] dwell_l;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               loop_l;
    logic               busy_q;
    logic               done_q;
    logic               stop_pend;
    logic               tick;
    logic               stop_now;
    logic               accept;
    logic [WIDTH-1:0]   duty_inc;
    logic [WIDTH-1:0]   duty_dec;

    pwm_period_timer #(.WIDTH(WIDTH)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .period_tick (tick)
    );

    assign accept   = (state == ST_IDLE) && bus.start;
    // A stop arriving on the tick cycle itself takes effect at that tick.
    assign stop_now = stop_pend | bus.stop;
    assign duty_inc = WIDTH'(sat_add(32'(duty_q), 32'(step_l), 32'(max_l)));
    assign duty_dec = WIDTH'(sat_sub(32'(duty_q), 32'(step_l), 32'(min_l)));

    // Config is captured once per sequence and needs no reset value.
    always_ff @(posedge clk) begin
        if (accept) begin
            min_l   <= bus.min_duty;
            max_l   <= bus.max_duty;
            step_l  <= (bus.step == '0) ? WIDTH'(1) : bus.step;
            dwell_l <= bus.dwell;
            loop_l  <= bus.loop;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            duty_q    <= '0;
            dwell_cnt <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE) begin
                if (bus.start) begin
                    state     <= ST_ARM;
                    busy_q    <= 1'b1;
                    stop_pend <= 1'b0;
                end
            end else begin
                if (bus.stop) begin
                    stop_pend <= 1'b1;
                end
                if (tick) begin
                    if (stop_now) begin
                        duty_q    <= min_l;
                        state     <= ST_IDLE;
                        busy_q    <= 1'b0;
                        stop_pend <= 1'b0;
                    end else begin
                        case (state)
                            ST_ARM: begin
                                duty_q <= min_l;
                                if (min_l >= max_l) begin
                                    // Degenerate range: hold min each period, or finish at once.
                                    if (!loop_l) begin
                                        state  <= ST_IDLE;
                                        busy_q <= 1'b0;
                                        done_q <= 1'b1;
                                    end
                                end else begin
                                    state     <= ST_UP;
                                    dwell_cnt <= dwell_l;
                                end
                            end
                            ST_UP: begin
                                if (dwell_cnt != '0) begin
                                    dwell_cnt <= dwell_cnt - 1'b1;
                                end else begin
                                    dwell_cnt <= dwell_l;
                                    if (duty_q == max_l) begin
                                        duty_q <= duty_dec;
                                        if (duty_dec != min_l) begin
                                            state <= ST_DOWN;
                                        end else if (!loop_l) begin
                                            state  <= ST_IDLE;
                                            busy_q <= 1'b0;
                                            done_q <= 1'b1;
                                        end
                                    end else begin
                                        duty_q <= duty_inc;
                                    end
                                end
                            end
                            ST_DOWN: begin
                                if (dwell_cnt != '0) begin
                                    dwell_cnt <= dwell_cnt - 1'b1;
                                end else begin
                                    dwell_cnt <= dwell_l;
                                    duty_q    <= duty_dec;
                                    if (duty_dec == min_l) begin
                                        if (loop_l) begin
                                            state <= ST_UP;
                                        end else begin
                                            state  <= ST_IDLE;
                                            busy_q <= 1'b0;
                                            done_q <= 1'b1;
                                        end
                                    end
                                end
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.duty        = duty_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.period_tick = tick;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl: stimulus queues per-period expectations,
// a negedge monitor compares them on the cycle after each period tick.
module tb_pwm_fade_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int W  = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pwm_fade_ctrl_if #(.WIDTH(W), .DWELL_W(DW)) bus ();

    pwm_fade_ctrl #(.WIDTH(W), .DWELL_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [W-1:0] duty;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   mcnt   = 0;
    logic last_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Independent period counter: tick expected on the 16th clock of each period.
    always @(posedge clk or negedge rst) begin
        if (!rst) mcnt <= 0;
        else      mcnt <= (mcnt + 1) % 16;
    end

    always @(negedge clk) begin
        if (rst) begin
            check("period_tick", 32'(bus.period_tick), 32'(mcnt == 15));
            if (last_tick && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("duty", 32'(bus.duty), 32'(mon_e.duty));
                check("busy", 32'(bus.busy), 32'(mon_e.busy));
                check("done", 32'(bus.done), 32'(mon_e.done));
            end
            last_tick = bus.period_tick;
        end else begin
            last_tick = 1'b0;
        end
    end

    task automatic push(input logic [W-1:0] d, input logic b, input logic dn);
        exp_q.push_back({d, b, dn});
    endtask

    // Align to a period start, pulse start, then scramble inputs to prove they were latched.
    task automatic sync_start(input logic [W-1:0] mn, input logic [W-1:0] mx, input logic [W-1:0] st,
                              input logic [DW-1:0] dw, input logic lp, input logic with_stop);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_tick && n < 40);
        if (!bus.period_tick) check("sync_tick_timeout", 32'(bus.period_tick), 32'd1);
        @(negedge clk);
        bus.min_duty = mn;
        bus.max_duty = mx;
        bus.step     = st;
        bus.dwell    = dw;
        bus.loop     = lp;
        bus.start    = 1'b1;
        bus.stop     = with_stop;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        bus.min_duty = 4'd7;
        bus.max_duty = 4'd0;
        bus.step     = 4'd9;
        bus.dwell    = 8'd5;
        bus.loop     = ~lp;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] t3_seq [16];
        int           done_seen;
        int           n;
        t3_seq = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3,
                   4'd3, 4'd2, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2};

        bus.start = 1'b0; bus.stop = 1'b0; bus.loop = 1'b0;
        bus.min_duty = '0; bus.max_duty = '0; bus.step = '0; bus.dwell = '0;

        repeat (3) @(negedge clk);
        check("rst_duty", 32'(bus.duty), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_tick", 32'(bus.period_tick), 32'd0);
        rst = 1'b1;

        // 2,5,8,5,2 one-shot
        sync_start(4'd2, 4'd8, 4'd3, 8'd0, 1'b0, 1'b0);
        check("t1_busy_on", 32'(bus.busy), 32'd1);
        push(4'd2, 1'b1, 1'b0); push(4'd5, 1'b1, 1'b0); push(4'd8, 1'b1, 1'b0);
        push(4'd5, 1'b1, 1'b0); push(4'd2, 1'b0, 1'b1);
        drain(120);
        @(negedge clk); #1;
        check("t1_done_clear", 32'(bus.done), 32'd0);
        check("t1_busy_low", 32'(bus.busy), 32'd0);

        // saturation at both ends
        sync_start(4'd10, 4'd15, 4'd4, 8'd0, 1'b0, 1'b0);
        push(4'd10, 1'b1, 1'b0); push(4'd14, 1'b1, 1'b0); push(4'd15, 1'b1, 1'b0);
        push(4'd11, 1'b1, 1'b0); push(4'd10, 1'b0, 1'b1);
        drain(120);

        // step of 0 behaves as 1
        sync_start(4'd0, 4'd2, 4'd0, 8'd0, 1'b0, 1'b0);
        push(4'd0, 1'b1, 1'b0); push(4'd1, 1'b1, 1'b0); push(4'd2, 1'b1, 1'b0);
        push(4'd1, 1'b1, 1'b0); push(4'd0, 1'b0, 1'b1);
        drain(120);

        // looping with dwell=2: every value held three periods
        sync_start(4'd1, 4'd3, 4'd1, 8'd2, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) push(t3_seq[i], 1'b1, 1'b0);
        drain(16 * 16 + 40);
        check("t3_busy_held", 32'(bus.busy), 32'd1);

        // stop mid-period: duty holds until the tick, then min, no done
        repeat (5) @(negedge clk);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("t4_duty_hold", 32'(bus.duty), 32'd2);
        check("t4_busy_hold", 32'(bus.busy), 32'd1);
        push(4'd1, 1'b0, 1'b0);
        drain(40);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("t4_no_done", 32'(done_seen), 32'd0);
        check("t4_busy_low", 32'(bus.busy), 32'd0);

        // min>=max one-shot, with stop dropped on start and a second start ignored
        sync_start(4'd9, 4'd3, 4'd1, 8'd0, 1'b0, 1'b1);
        @(negedge clk);
        bus.min_duty = 4'd0; bus.max_duty = 4'd15; bus.step = 4'd1; bus.loop = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        push(4'd9, 1'b0, 1'b1);
        drain(40);
        repeat (20) @(negedge clk);
        check("t5_busy_low", 32'(bus.busy), 32'd0);
        check("t5_duty_kept", 32'(bus.duty), 32'd9);

        // asynchronous reset mid-ramp
        sync_start(4'd2, 4'd8, 4'd3, 8'd0, 1'b0, 1'b0);
        push(4'd2, 1'b1, 1'b0); push(4'd5, 1'b1, 1'b0);
        drain(60);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_duty", 32'(bus.duty), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_done", 32'(bus.done), 32'd0);
        check("t6_rst_tick", 32'(bus.period_tick), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.period_tick && n < 40);
        check("t6_first_tick", 32'(n), 32'd15);
        check("t6_duty_after", 32'(bus.duty), 32'd0);
        check("t6_busy_after", 32'(bus.busy), 32'd0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
